tff_bank_ctrl: RTL and testbench
================================

// Module: tff_bank_ctrl
// PURPOSE
//  Sequencer/arbiter for a bank of NCELLS temporal flip-flop cells (WE/RE/rstb/out ring cells).
//  - Converts write values into WE pulse widths and read events into cycle counts.
//  - Arbitrates clear, write and read requesters onto the bank; one cell operation at a time.
//  - Sits between the digital request side and the analog-timed cell array.
// PARAMETERS
//  NCELLS      8   number of cells driven (1..256)
//  AW          3   address width; must satisfy 2**AW >= NCELLS
//  CW          6   value/counter width; max encodable time = 2**CW-1 cycles
//  CLR_CYCLES  4   cycles cell_rstb is held low per clear (>=1)
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  clr_req    in   1       level; clear cell clr_addr, held until clr_ack
//  clr_addr   in   AW      cell to clear
//  clr_ack    out  1       1-cycle pulse: clear done
//  wr_req     in   1       level; write wr_val into cell wr_addr, held until wr_ack
//  wr_addr    in   AW      cell to write
//  wr_val     in   CW      time code = WE pulse width in cycles
//  wr_ack     out  1       1-cycle pulse: write done
//  rd_req     in   1       level; read cell rd_addr, held until rd_ack
//  rd_addr    in   AW      cell to read
//  rd_ack     out  1       1-cycle pulse: rd_val/rd_timeout valid this cycle only
//  rd_val     out  CW      measured cycle count
//  rd_timeout out  1       read ended without event, or bad address
//  cell_we    out  NCELLS  per-cell WE, one-hot or zero
//  cell_re    out  NCELLS  per-cell RE, one-hot or zero
//  cell_rstb  out  NCELLS  per-cell active-low cell clear
//  cell_evt   in   NCELLS  per-cell out, asynchronous to clk
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all acks 0, rd_val=0, rd_timeout=0, cell_we=0, cell_re=0,
//    cell_rstb=all 0 while rst high (bank cleared), all 1 the cycle after rst drops; rr=write.
//  cell_evt: 2-flop sync per bit plus 3rd flop; event = synced rising edge (sync regs reset to 0).
//  FSM IDLE/CLEAR/WRITE/READ/ACK. Grant only in IDLE; address/value captured at grant.
//  Priority: clr_req > {wr_req, rd_req}; wr vs rd round-robin.
//    rr flips to the other side after each granted wr or rd.
//  CLEAR: cycles G+1..G+CLR_CYCLES, cell_rstb[a]=0 (others stay 1); clr_ack at G+CLR_CYCLES+1.
//  WRITE: cell_we[a]=1 exactly wr_val cycles starting G+1; wr_ack in the cycle after WE drops.
//    wr_val=0: no WE, wr_ack at G+1.
//  READ: cell_re[a]=1 from G+1; counter=0 at G+1, +1 per cycle.
//    Event on cell a detected at counter k: RE drops and rd_ack=1 with rd_val=k, rd_timeout=0,
//    both in that same cycle. Counter reaching 2**CW-1 with no event:
//    rd_ack, rd_val=all-ones, rd_timeout=1.
//    Events on non-selected cells are ignored.
//  ACK: one-cycle state after every ack; returns to IDLE.
//    Back-to-back grants are therefore >=2 cycles apart; requesters drop req on the cycle after ack.
//  Address >= NCELLS: no cell line toggles; ack at G+1; a read also sets rd_timeout=1, rd_val=0.
//  rst mid-operation: aborts immediately; all cell_we/cell_re=0, cell_rstb=0; no ack issued.
//  At most one bit of cell_we|cell_re|~cell_rstb is active outside reset (verified by assertion).
// TESTING
//  1. Reset 3 cycles -> cell_rstb=0x00 during rst, 0xFF after; busy=0, all acks 0.
//  2. clr_req addr=2, CLR_CYCLES=4 -> cell_rstb[2] low 4 cycles, clr_ack 1 cycle later.
//  3. wr_req addr=5 val=9 -> cell_we[5] high exactly 9 cycles, wr_ack next cycle.
//     Same with val=0 -> no WE, wr_ack at G+1.
//  4. rd_req addr=1, cell model raises evt[1] 7 cycles after RE ->
//     rd_ack with rd_val=10, rd_timeout=0 (3-cycle sync).
//     No event -> rd_val=63, rd_timeout=1.
//  5. wr_req, rd_req and clr_req all held -> order: clr, wr, rd, wr, ...
//     Round-robin alternation holds; never two cells active at once.
//  6. rst asserted mid-write (val=20, cycle 5) -> WE drops next edge, no wr_ack.
//     Also rd_addr=9 with NCELLS=8 -> rd_ack at G+1, rd_timeout=1.

Source files
------------

// File: rtl/tff_bank_ctrl.sv
// tff_bank_ctrl: sequencer/arbiter for a bank of NCELLS temporal flip-flop cells.
// It turns write values into WE pulse widths and read events into cycle counts.
// It runs only one cell operation at a time.
//
// Ports
//   clk, rst                 : clock and synchronous active-high reset
//   clr_req/clr_addr/clr_ack : clear request (level), target cell, 1-cycle done pulse
//   wr_req/wr_addr/wr_val/wr_ack : write request, target cell, WE width in cycles, done pulse
//   rd_req/rd_addr/rd_ack    : read request, target cell, done pulse
//   rd_val/rd_timeout        : measured count and no-event/bad-address flag, valid with rd_ack
//   cell_we/cell_re          : per-cell write/read enables (one-hot or zero)
//   cell_rstb                : per-cell active-low clear
//   cell_evt                 : per-cell output, asynchronous to clk
//   busy                     : controller not idle
module tff_bank_ctrl #(
  parameter int NCELLS     = 8,
  parameter int AW         = 3,
  parameter int CW         = 6,
  parameter int CLR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic [AW-1:0]     clr_addr,
  output logic              clr_ack,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CW-1:0]     wr_val,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_ack,
  output logic [CW-1:0]     rd_val,
  output logic              rd_timeout,
  output logic [NCELLS-1:0] cell_we,
  output logic [NCELLS-1:0] cell_re,
  output logic [NCELLS-1:0] cell_rstb,
  input  logic [NCELLS-1:0] cell_evt,
  output logic              busy
);

  localparam int CLRW = $clog2(CLR_CYCLES + 1);
  localparam int CNTW = (CW > CLRW) ? CW : CLRW;
  localparam logic [CW-1:0] VMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WRITE, S_READ, S_ACK} state_t;

  state_t            state, state_nxt;
  logic              rst_q;
  logic [AW-1:0]     addr_q;
  logic [CW-1:0]     val_q;
  logic              bad_q;
  logic              rr_rd;
  logic [CNTW-1:0]   cnt;
  logic [NCELLS-1:0] evt_s1, evt_s2, evt_s3, evt_edge;
  logic [NCELLS-1:0] sel;
  logic              grant_clr, grant_wr, grant_rd, grant_any;
  logic [AW-1:0]     gaddr;
  logic [31:0]       gaddr_ext;
  logic              rd_hit, op_done;

  // Arbitration: clear wins; write/read alternate when both are pending.
  always_comb begin
    grant_clr = (state == S_IDLE) && clr_req;
    grant_wr  = (state == S_IDLE) && !clr_req && wr_req && (!rd_req || !rr_rd);
    grant_rd  = (state == S_IDLE) && !clr_req && rd_req && (!wr_req || rr_rd);
    grant_any = grant_clr | grant_wr | grant_rd;
    gaddr     = grant_clr ? clr_addr : (grant_wr ? wr_addr : rd_addr);
    gaddr_ext = 32'(gaddr);
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NCELLS; i++)
      sel[i] = !bad_q && (addr_q == AW'(i));
  end

  // The edge is registered once more, so an event lands 3 cycles after cell_evt rises.
  assign rd_hit = |(evt_edge & sel);

  always_comb begin
    op_done = 1'b0;
    unique case (state)
      S_CLEAR: op_done = bad_q || (cnt == CNTW'(CLR_CYCLES));
      S_WRITE: op_done = bad_q || (cnt == CNTW'(val_q));
      S_READ:  op_done = bad_q || rd_hit || (cnt == CNTW'(VMAX));
      default: op_done = 1'b0;
    endcase
  end

  // State register plus captured operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rst_q    <= 1'b1;
      addr_q   <= '0;
      val_q    <= '0;
      bad_q    <= 1'b0;
      rr_rd    <= 1'b0;
      cnt      <= '0;
      evt_s1   <= '0;
      evt_s2   <= '0;
      evt_s3   <= '0;
      evt_edge <= '0;
    end else begin
      state    <= state_nxt;
      rst_q    <= 1'b0;
      evt_s1   <= cell_evt;
      evt_s2   <= evt_s1;
      evt_s3   <= evt_s2;
      evt_edge <= evt_s2 & ~evt_s3;
      if (grant_any) begin
        cnt    <= '0;
        addr_q <= gaddr;
        val_q  <= wr_val;
        bad_q  <= (gaddr_ext >= 32'(NCELLS));
        if (grant_wr) rr_rd <= 1'b1;
        if (grant_rd) rr_rd <= 1'b0;
      end else if (state != S_IDLE && state != S_ACK) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (grant_clr)     state_nxt = S_CLEAR;
        else if (grant_wr) state_nxt = S_WRITE;
        else if (grant_rd) state_nxt = S_READ;
      end
      S_CLEAR, S_WRITE, S_READ: if (op_done) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: the final cycle of each operation carries the ack and drops the cell line.
  always_comb begin
    clr_ack    = 1'b0;
    wr_ack     = 1'b0;
    rd_ack     = 1'b0;
    rd_val     = '0;
    rd_timeout = 1'b0;
    cell_we    = '0;
    cell_re    = '0;
    cell_rstb  = rst_q ? '0 : '1;
    if (!rst_q) begin
      unique case (state)
        S_CLEAR: begin
          if (op_done) clr_ack = 1'b1;
          else         cell_rstb = ~sel;
        end
        S_WRITE: begin
          if (op_done) wr_ack = 1'b1;
          else         cell_we = sel;
        end
        S_READ: begin
          if (op_done) begin
            rd_ack     = 1'b1;
            rd_timeout = bad_q || !rd_hit;
            rd_val     = bad_q ? '0 : cnt[CW-1:0];
          end else begin
            cell_re = sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  a_one_cell: assert property (@(posedge clk) disable iff (rst || rst_q)
    $onehot0(cell_we | cell_re | ~cell_rstb));

endmodule

// File: tb/tb_tff_bank_ctrl.sv
module tb_tff_bank_ctrl;
  localparam int NCELLS = 8, AW = 4, CW = 6, CLR_CYCLES = 4;

  logic              clk = 1'b0, rst = 1'b1;
  logic              clr_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0]     clr_addr = '0, wr_addr = '0, rd_addr = '0;
  logic [CW-1:0]     wr_val = '0;
  logic              clr_ack, wr_ack, rd_ack, rd_timeout, busy;
  logic [CW-1:0]     rd_val;
  logic [NCELLS-1:0] cell_we, cell_re, cell_rstb;
  logic [NCELLS-1:0] cell_evt = '0;

  tff_bank_ctrl #(.NCELLS(NCELLS), .AW(AW), .CW(CW), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .clr_req(clr_req), .clr_addr(clr_addr), .clr_ack(clr_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_val(wr_val), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_val(rd_val),
    .rd_timeout(rd_timeout), .cell_we(cell_we), .cell_re(cell_re),
    .cell_rstb(cell_rstb), .cell_evt(cell_evt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int at; logic [CW-1:0] val; logic tmo; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cell_rstb !== 8'h00 || busy !== 1'b0 || {clr_ack, wr_ack, rd_ack} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold rstb=%h busy=%b acks=%b required rstb=00 busy=0 acks=000",
                 cell_rstb, busy, {clr_ack, wr_ack, rd_ack});
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (cell_rstb !== 8'hFF || busy !== 1'b0 || cell_we !== 8'h00 || cell_re !== 8'h00
        || rd_val !== 6'd0 || rd_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rstb=%h busy=%b we=%h re=%h rd_val=%0d tmo=%b required FF 0 00 00 0 0",
               cell_rstb, busy, cell_we, cell_re, rd_val, rd_timeout);
    end
  endtask

  task automatic test_clear(input logic [AW-1:0] a);
    exp_t e;
    int g, k;
    bit done = 0, bad;
    logic [NCELLS-1:0] exp_rstb;
    wait_idle();
    bad = (a >= NCELLS);
    clr_addr = a; clr_req = 1'b1; g = cyc;
    e.kind = 0; e.at = bad ? 1 : CLR_CYCLES + 1; e.val = '0; e.tmo = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      k = cyc - g;
      exp_rstb = (!bad && k >= 1 && k <= CLR_CYCLES) ? ~(8'(1) << a) : 8'hFF;
      checks++;
      if (cell_rstb !== exp_rstb) begin
        errors++;
        $display("FAIL clr_rstb a=%0d k=%0d got %h required %h", a, k, cell_rstb, exp_rstb);
      end
      if (clr_ack === 1'b1) begin
        done = 1; clr_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (k != e.at) begin
          errors++;
          $display("FAIL clr_ack_time a=%0d got k=%0d required k=%0d", a, k, e.at);
        end
      end
    end
    if (!done) begin
      checks++; errors++; clr_req = 1'b0; void'(sb.pop_front());
      $display("FAIL clr_timeout a=%0d no clr_ack seen, required one", a);
    end
  endtask

  task automatic test_write(input logic [AW-1:0] a, input int v);
    exp_t e;
    int g, k;
    bit done = 0, bad;
    logic [NCELLS-1:0] exp_we;
    wait_idle();
    bad = (a >= NCELLS);
    wr_addr = a; wr_val = CW'(v); wr_req = 1'b1; g = cyc;
    e.kind = 1; e.at = bad ? 1 : v + 1; e.val = '0; e.tmo = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      k = cyc - g;
      exp_we = (!bad && k >= 1 && k <= v) ? (8'(1) << a) : 8'h00;
      checks++;
      if (cell_we !== exp_we) begin
        errors++;
        $display("FAIL wr_we a=%0d v=%0d k=%0d got %h required %h", a, v, k, cell_we, exp_we);
      end
      if (wr_ack === 1'b1) begin
        done = 1; wr_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (k != e.at) begin
          errors++;
          $display("FAIL wr_ack_time a=%0d v=%0d got k=%0d required k=%0d", a, v, k, e.at);
        end
      end
    end
    if (!done) begin
      checks++; errors++; wr_req = 1'b0; void'(sb.pop_front());
      $display("FAIL wr_timeout a=%0d v=%0d no wr_ack seen, required one", a, v);
    end
  endtask

  // delay < 0: the selected cell never fires; a stray event is pulsed on cell 'stray'.
  task automatic test_read(input logic [AW-1:0] a, input int delay, input int stray);
    exp_t e;
    int g, k;
    bit done = 0, bad;
    logic [NCELLS-1:0] exp_re;
    wait_idle();
    bad = (a >= NCELLS);
    rd_addr = a; rd_req = 1'b1; g = cyc;
    e.kind = 2;
    if (bad)             begin e.at = 1;         e.val = '0;           e.tmo = 1'b1; end
    else if (delay >= 0) begin e.at = delay + 4; e.val = CW'(delay+3); e.tmo = 1'b0; end
    else                 begin e.at = 64;        e.val = 6'd63;        e.tmo = 1'b1; end
    sb.push_back(e);
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      k = cyc - g;
      exp_re = (!bad && k >= 1 && k < e.at) ? (8'(1) << a) : 8'h00;
      checks++;
      if (cell_re !== exp_re) begin
        errors++;
        $display("FAIL rd_re a=%0d k=%0d got %h required %h", a, k, cell_re, exp_re);
      end
      if (rd_ack === 1'b1) begin
        done = 1; rd_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (k != e.at || rd_val !== e.val || rd_timeout !== e.tmo) begin
          errors++;
          $display("FAIL rd_result a=%0d got k=%0d val=%0d tmo=%b required k=%0d val=%0d tmo=%b",
                   a, k, rd_val, rd_timeout, e.at, e.val, e.tmo);
        end
      end
      if (!bad && delay >= 0 && k == delay + 1) cell_evt[a] = 1'b1;
      if (!bad && delay < 0 && k == 5) cell_evt[stray] = 1'b1;
      if (!bad && delay < 0 && k == 7) cell_evt[stray] = 1'b0;
    end
    if (!done) begin
      checks++; errors++; rd_req = 1'b0; void'(sb.pop_front());
      $display("FAIL rd_timeout_wait a=%0d no rd_ack seen, required one", a);
    end
    cell_evt = '0;
  endtask

  task automatic test_reset_mid_write();
    int g, k;
    bit ack_seen = 0;
    wait_idle();
    wr_addr = 4'd4; wr_val = 6'd20; wr_req = 1'b1; g = cyc;
    for (int i = 0; i < 5; i++) tick();
    k = cyc - g;
    checks++;
    if (cell_we !== 8'h10) begin
      errors++;
      $display("FAIL midwr_we_before k=%0d got %h required 10", k, cell_we);
    end
    rst = 1'b1; wr_req = 1'b0;
    tick();
    checks++;
    if (cell_we !== 8'h00 || cell_rstb !== 8'h00 || wr_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midwr_abort we=%h rstb=%h ack=%b busy=%b required 00 00 0 0",
               cell_we, cell_rstb, wr_ack, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (cell_rstb !== 8'hFF) begin
      errors++;
      $display("FAIL midwr_release rstb=%h required FF", cell_rstb);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (wr_ack === 1'b1 || cell_we !== 8'h00) ack_seen = 1;
    end
    checks++;
    if (ack_seen) begin
      errors++;
      $display("FAIL midwr_no_ack got ack/we activity after abort, required none");
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int n = 0, kind, nack;
    bit wr_drop = 0, rd_drop = 0;
    int order[6] = '{0, 1, 2, 1, 2, 1};
    wait_idle();
    foreach (order[i]) begin
      e.kind = order[i]; e.at = -1; e.val = 6'd3; e.tmo = 1'b0;
      sb.push_back(e);
    end
    clr_addr = 4'd0; wr_addr = 4'd3; wr_val = 6'd2; rd_addr = 4'd6;
    clr_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 400 && n < 6; i++) begin
      tick();
      checks++;
      if (!$onehot0(cell_we | cell_re | ~cell_rstb)) begin
        errors++;
        $display("FAIL rr_onehot we=%h re=%h rstb=%h required at most one active",
                 cell_we, cell_re, cell_rstb);
      end
      if (wr_drop) begin wr_req = 1'b1; wr_drop = 0; end
      if (rd_drop) begin rd_req = 1'b1; rd_drop = 0; end
      if (cell_re[6] && !cell_evt[6]) cell_evt[6] = 1'b1;
      nack = int'(clr_ack) + int'(wr_ack) + int'(rd_ack);
      if (nack != 0) begin
        kind = clr_ack ? 0 : (wr_ack ? 1 : 2);
        e = sb.pop_front();
        n++;
        checks++;
        if (nack != 1 || kind != e.kind) begin
          errors++;
          $display("FAIL rr_order grant#%0d got kind=%0d (acks=%0d) required kind=%0d",
                   n, kind, nack, e.kind);
        end
        if (kind == 2) begin
          checks++;
          if (rd_val !== e.val || rd_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rr_rd_val got %0d tmo=%b required %0d tmo=0", rd_val, rd_timeout, e.val);
          end
          cell_evt[6] = 1'b0;
        end
        if (kind == 0) clr_req = 1'b0;
        if (kind == 1) begin wr_req = 1'b0; wr_drop = 1; end
        if (kind == 2) begin rd_req = 1'b0; rd_drop = 1; end
      end
    end
    clr_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL rr_count got %0d acks required 6", n);
    end
    while (sb.size() > 0) void'(sb.pop_front());
    cell_evt = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_clear(4'd2);
    test_write(4'd5, 9);
    test_write(4'd5, 0);
    test_read(4'd1, 7, 0);
    test_read(4'd1, -1, 3);
    test_read(4'd9, -1, 0);
    test_write(4'd12, 5);
    test_clear(4'd15);
    test_reset_mid_write();
    test_round_robin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
